oam_dma_ctrl: RTL and testbench

- OAM DMA engine for the DMG core: copies a block of bytes from a source page (`{src_page, 8'h00}` upward) into the OAM dual-port RAM's write port.
- Paced by the system M-cycle strobe: one byte per tick.
- Sits between the CPU `0xFF46` register decode, the source memory read port and OAM port A.
- Drives `cpu_block` so the CPU bus arbiter can lock out non-HRAM accesses while a transfer runs.

---
 rtl/oam_dma_ctrl.sv | 100 ++++++++++
 tb/tb_oam_dma_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_ctrl.sv
// OAM DMA engine: copies LENGTH bytes from {src_page, 8'h00} upward
// into OAM port A, one byte per M-cycle tick.
module oam_dma_ctrl #(
    parameter int LENGTH     = 160,
    parameter int DATA_WIDTH = 8,
    localparam int AW = (LENGTH > 1) ? $clog2(LENGTH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick,
    input  logic                  start,
    input  logic [7:0]            src_page,
    output logic                  src_rd,
    output logic [15:0]           src_addr,
    input  logic [DATA_WIDTH-1:0] src_data,
    output logic                  oam_we,
    output logic [AW-1:0]         oam_addr,
    output logic [DATA_WIDTH-1:0] oam_din,
    output logic                  busy,
    output logic                  cpu_block,
    output logic                  done
);

    localparam int IW = AW + 1;
    localparam logic [IW-1:0] LAST = IW'(LENGTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        READ,
        WRITE
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    page_q, page_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          done_q, done_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            page_q  <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    // start takes priority in every state so a restart never finishes
    // the aborted read with a write or a done pulse
    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        src_rd  = 1'b0;
        oam_we  = 1'b0;
        oam_din = '0;
        if (start) begin
            page_d  = src_page;
            idx_d   = '0;
            state_d = DELAY;
        end else begin
            unique case (state_q)
                IDLE: state_d = IDLE;
                DELAY: begin
                    if (tick) state_d = READ;
                end
                READ: begin
                    if (tick) begin
                        src_rd  = 1'b1;
                        state_d = WRITE;
                    end
                end
                WRITE: begin
                    oam_we  = 1'b1;
                    oam_din = src_data;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = READ;
                    end
                end
            endcase
        end
    end

    assign src_addr  = {page_q, 8'(idx_q)};
    assign oam_addr  = idx_q[AW-1:0];
    assign busy      = (state_q != IDLE);
    assign cpu_block = (state_q == READ) || (state_q == WRITE);
    assign done      = done_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: a LENGTH=160 instance and a LENGTH=4
// instance sharing clock, reset and tick.
module tb_oam_dma_ctrl;

    logic        clk = 1'b0;
    logic        reset, tick, start, start4;
    logic [7:0]  src_page, src_page4;

    logic        src_rd, oam_we, busy, cpu_block, done;
    logic [15:0] src_addr;
    logic [7:0]  src_data, oam_din, oam_addr;

    logic        src_rd4, oam_we4, busy4, cpu_block4, done4;
    logic [15:0] src_addr4;
    logic [7:0]  src_data4, oam_din4;
    logic [1:0]  oam_addr4;

    oam_dma_ctrl #(.LENGTH(160), .DATA_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start),
        .src_page(src_page), .src_rd(src_rd), .src_addr(src_addr),
        .src_data(src_data), .oam_we(oam_we), .oam_addr(oam_addr),
        .oam_din(oam_din), .busy(busy), .cpu_block(cpu_block), .done(done)
    );

    oam_dma_ctrl #(.LENGTH(4), .DATA_WIDTH(8)) dut4 (
        .clk(clk), .reset(reset), .tick(tick), .start(start4),
        .src_page(src_page4), .src_rd(src_rd4), .src_addr(src_addr4),
        .src_data(src_data4), .oam_we(oam_we4), .oam_addr(oam_addr4),
        .oam_din(oam_din4), .busy(busy4), .cpu_block(cpu_block4), .done(done4)
    );

    initial forever #5 clk = ~clk;

    // registered source memory: data = addr[7:0] ^ 0x5A
    always @(posedge clk) if (src_rd) src_data <= src_addr[7:0] ^ 8'h5A;
    always @(posedge clk) if (src_rd4) src_data4 <= src_addr4[7:0] ^ 8'h5A;

    // mode 0: no ticks, 1: every 4 clk, 2: every clk
    int mode = 0;
    int ph = 0;
    initial begin
        tick = 1'b0;
        forever begin
            @(posedge clk); #1;
            tick = (mode == 2) || (mode == 1 && ph == 0);
            ph = (ph + 1) % 4;
        end
    end

    int cyc = 0, tick_cnt = 0;
    int st_tick = 0, first_rel = -1, st4 = 0, first_rel4 = -1;
    bit rd_seen = 0, rd4_seen = 0;
    logic prev_rd = 0, prev_rd4 = 0;
    int we_viol = 0, rd_viol = 0, done_cnt = 0;
    int we_viol4 = 0, rd_viol4 = 0, done_cnt4 = 0;
    int last_we4 = 0, done_cyc4 = 0;
    logic [15:0] rd_q[$], rd4_q[$];
    logic [7:0]  wa_q[$], wd_q[$], wa4_q[$], wd4_q[$];

    initial forever begin
        @(negedge clk);
        cyc++;
        if (tick) tick_cnt++;
        if (start) begin st_tick = tick_cnt; rd_seen = 0; end
        if (start4) begin st4 = tick_cnt; rd4_seen = 0; end
        if (src_rd) begin
            rd_q.push_back(src_addr);
            if (!rd_seen) begin first_rel = tick_cnt - st_tick; rd_seen = 1; end
            if (prev_rd) rd_viol++;
        end
        if (oam_we) begin
            wa_q.push_back(oam_addr);
            wd_q.push_back(oam_din);
            if (!prev_rd) we_viol++;
        end
        if (done) done_cnt++;
        prev_rd = src_rd;
        if (src_rd4) begin
            rd4_q.push_back(src_addr4);
            if (!rd4_seen) begin first_rel4 = tick_cnt - st4; rd4_seen = 1; end
            if (prev_rd4) rd_viol4++;
        end
        if (oam_we4) begin
            wa4_q.push_back({6'd0, oam_addr4});
            wd4_q.push_back(oam_din4);
            last_we4 = cyc;
            if (!prev_rd4) we_viol4++;
        end
        if (done4) begin done_cnt4++; done_cyc4 = cyc; end
        prev_rd4 = src_rd4;
    end

    int passed = 0, fails = 0, total = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nclk(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic pulse_start(input logic [7:0] pg);
        @(posedge clk); #1;
        src_page = pg;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_wr(input int target, input string tag);
        int n;
        n = 0;
        while (wa_q.size() < target && n < 3000) begin
            @(negedge clk); #1; n++;
        end
        chk(tag, wa_q.size(), target);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 3000) begin
            @(negedge clk); #1; n++;
        end
        chk({tag, " done"}, done, 1);
        chk({tag, " busy at done"}, busy, 0);
        chk({tag, " cpu_block at done"}, cpu_block, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " src_rd"}, src_rd, 0);
        chk({tag, " oam_we"}, oam_we, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " cpu_block"}, cpu_block, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " src_addr"}, src_addr, 0);
        chk({tag, " oam_addr"}, oam_addr, 0);
        chk({tag, " oam_din"}, oam_din, 0);
    endtask

    initial begin
        int wb, rb, d0, n;
        reset = 1'b1;
        start = 1'b0;
        start4 = 1'b0;
        src_page = 8'h00;
        src_page4 = 8'h00;
        nclk(3);
        chk_zero("reset");
        chk("reset busy4", busy4, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        mode = 1;
        nclk(2);
        chk_zero("idle");

        // basic copy from page 0xC1
        wb = wa_q.size(); rb = rd_q.size(); d0 = done_cnt;
        pulse_start(8'hC1);
        chk("basic busy in delay", busy, 1);
        chk("basic cpu_block in delay", cpu_block, 0);
        n = 0;
        while (src_rd !== 1'b1 && n < 100) begin @(negedge clk); #1; n++; end
        chk("basic first src_rd", src_rd, 1);
        chk("basic cpu_block in read", cpu_block, 1);
        chk("basic first rd tick", first_rel, 2);
        chk("basic first src_addr", src_addr, 16'hC100);
        wait_done("basic");
        chk("basic writes", wa_q.size() - wb, 160);
        chk("basic reads", rd_q.size() - rb, 160);
        chk("basic last src_addr", rd_q[rb + 159], 16'hC19F);
        for (int i = 0; i < 160; i++) begin
            chk("basic oam_addr", wa_q[wb + i], i);
            chk("basic oam_din", wd_q[wb + i], i[7:0] ^ 8'h5A);
        end
        nclk(3);
        chk("basic done count", done_cnt - d0, 1);
        chk("basic busy after", busy, 0);

        // restart after 50 writes
        wb = wa_q.size(); d0 = done_cnt;
        pulse_start(8'h80);
        wait_wr(wb + 50, "restart first 50");
        pulse_start(8'h90);
        chk("restart busy", busy, 1);
        chk("restart cpu_block in delay", cpu_block, 0);
        chk("restart no extra write", wa_q.size() - wb, 50);
        chk("restart no done", done_cnt - d0, 0);
        wb = wa_q.size(); rb = rd_q.size();
        wait_done("restart");
        chk("restart writes", wa_q.size() - wb, 160);
        chk("restart first oam_addr", wa_q[wb], 0);
        chk("restart first src_addr", rd_q[rb], 16'h9000);
        chk("restart last src_addr", rd_q[rb + 159], 16'h909F);
        chk("restart last oam_din", wd_q[wb + 159], 8'hC5);
        nclk(3);
        chk("restart done count", done_cnt - d0, 1);

        // asynchronous reset mid-transfer at byte 70
        wb = wa_q.size(); d0 = done_cnt;
        pulse_start(8'h33);
        wait_wr(wb + 70, "areset 70 writes");
        #1 reset = 1'b1;
        #1 chk_zero("areset");
        @(posedge clk); #1;
        reset = 1'b0;
        wb = wa_q.size(); rb = rd_q.size();
        nclk(40);
        chk("areset no writes", wa_q.size() - wb, 0);
        chk("areset no reads", rd_q.size() - rb, 0);
        chk("areset no done", done_cnt - d0, 0);
        chk("areset busy", busy, 0);

        // tick stall in READ
        wb = wa_q.size(); rb = rd_q.size(); d0 = done_cnt;
        pulse_start(8'h44);
        wait_wr(wb + 10, "stall 10 writes");
        mode = 0;
        nclk(20);
        chk("stall writes", wa_q.size() - wb, 10);
        chk("stall reads", rd_q.size() - rb, 10);
        chk("stall src_rd", src_rd, 0);
        chk("stall cpu_block", cpu_block, 1);
        chk("stall busy", busy, 1);
        mode = 1;
        wait_done("stall");
        chk("stall total writes", wa_q.size() - wb, 160);
        for (int i = 0; i < 160; i++) begin
            chk("stall oam_addr", wa_q[wb + i], i);
            chk("stall src_addr", rd_q[rb + i], 16'h4400 + i);
        end
        nclk(3);
        chk("stall done count", done_cnt - d0, 1);
        chk("timing oam_we after src_rd", we_viol, 0);
        chk("timing no back-to-back src_rd", rd_viol, 0);

        // LENGTH=4 instance, tick every clk (tick also lands in WRITE)
        mode = 2;
        @(posedge clk); #1;
        src_page4 = 8'h12;
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        n = 0;
        while (done4 !== 1'b1 && n < 200) begin @(negedge clk); #1; n++; end
        chk("len4 done", done4, 1);
        chk("len4 busy at done", busy4, 0);
        chk("len4 writes", wa4_q.size(), 4);
        chk("len4 reads", rd4_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("len4 oam_addr", wa4_q[i], i);
            chk("len4 oam_din", wd4_q[i], i[7:0] ^ 8'h5A);
            chk("len4 src_addr", rd4_q[i], 16'h1200 + i);
        end
        chk("len4 done after last write", done_cyc4 - last_we4, 1);
        chk("len4 first rd tick", first_rel4, 2);
        chk("len4 tick in write ignored", rd_viol4, 0);
        chk("len4 oam_we after src_rd", we_viol4, 0);
        nclk(5);
        chk("len4 done count", done_cnt4, 1);
        chk("len4 idle after", busy4, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
